// File: rtl/instr_fetch_decode_if.sv
// Bus between the fetch/decode block, its instruction memory and the downstream datapath.
// The master side is the fetch/decode block; the slave side is memory plus datapath.
interface instr_fetch_decode_if;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  opcode;
    logic [1:0]  reg1;
    logic [1:0]  reg2;
    logic [7:0]  address;

    modport master (
        output imem_addr, imem_rd_en,
        input  imem_rdata,
        output issue_valid,
        input  issue_ready,
        output opcode, reg1, reg2, address
    );

    modport slave (
        input  imem_addr, imem_rd_en,
        output imem_rdata,
        input  issue_valid,
        output issue_ready,
        input  opcode, reg1, reg2, address
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode sequencer: fetches one 16-bit word per instruction, resolves JMP/BZ/HALT
// locally and issues every other opcode to the datapath with a valid/ready handshake.
module instr_fetch_decode #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] OPC_JMP  = 4'hD,
    parameter logic [3:0] OPC_BZ   = 4'hE,
    parameter logic [3:0] OPC_HALT = 4'hF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        zero,
    output logic [7:0]                  pc,
    output logic                        busy,
    output logic                        halted,
    instr_fetch_decode_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] ir_reg, ir_next;
    logic [3:0]  opcode_reg, opcode_next;
    logic [1:0]  reg1_reg, reg1_next;
    logic [1:0]  reg2_reg, reg2_next;
    logic [7:0]  address_reg, address_next;

    logic [3:0]  ir_opcode;
    logic [7:0]  ir_address;

    assign ir_opcode  = ir_reg[15:12];
    assign ir_address = ir_reg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            pc_reg      <= RESET_PC;
            ir_reg      <= 16'h0000;
            opcode_reg  <= 4'h0;
            reg1_reg    <= 2'b00;
            reg2_reg    <= 2'b00;
            address_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            opcode_reg  <= opcode_next;
            reg1_reg    <= reg1_next;
            reg2_reg    <= reg2_next;
            address_reg <= address_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        opcode_next  = opcode_reg;
        reg1_next    = reg1_reg;
        reg2_next    = reg2_reg;
        address_next = address_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                ir_next    = bus.imem_rdata;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Control-flow opcodes never reach the datapath, so the issued fields keep their old values.
                if (ir_opcode == OPC_HALT) begin
                    state_next = S_HALTED;
                end else if (ir_opcode == OPC_JMP) begin
                    pc_next    = ir_address;
                    state_next = S_FETCH;
                end else if (ir_opcode == OPC_BZ) begin
                    pc_next    = zero ? ir_address : pc_reg + 8'd1;
                    state_next = S_FETCH;
                end else begin
                    opcode_next  = ir_reg[15:12];
                    reg1_next    = ir_reg[11:10];
                    reg2_next    = ir_reg[9:8];
                    address_next = ir_reg[7:0];
                    pc_next      = pc_reg + 8'd1;
                    state_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.issue_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The address bus is parked at zero whenever no read is being requested.
    assign bus.imem_rd_en  = (state_reg == S_FETCH);
    assign bus.imem_addr   = (state_reg == S_FETCH) ? pc_reg : 8'h00;
    assign bus.issue_valid = (state_reg == S_ISSUE);
    assign bus.opcode      = opcode_reg;
    assign bus.reg1        = reg1_reg;
    assign bus.reg2        = reg2_reg;
    assign bus.address     = address_reg;

    assign pc     = pc_reg;
    assign busy   = (state_reg != S_IDLE) && (state_reg != S_HALTED);
    assign halted = (state_reg == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: a registered-read memory model, a negedge monitor feeding
// observed fetches/issues into queues, and per-scenario tasks comparing them to expectations.
module tb_instr_fetch_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       zero = 1'b0;
    logic [7:0] pc0, pc1;
    logic       busy0, busy1, halted0, halted1;

    instr_fetch_decode_if bus0();
    instr_fetch_decode_if bus1();

    instr_fetch_decode #(.RESET_PC(8'h00)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .zero(zero),
        .pc(pc0), .busy(busy0), .halted(halted0), .bus(bus0)
    );

    instr_fetch_decode #(.RESET_PC(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .zero(zero),
        .pc(pc1), .busy(busy1), .halted(halted1), .bus(bus1)
    );

    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        if (bus0.imem_rd_en) bus0.imem_rdata <= mem[bus0.imem_addr];
        if (bus1.imem_rd_en) bus1.imem_rdata <= mem[bus1.imem_addr];
    end

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] obs1_q[$];
    logic [7:0]  fexp_q[$];
    logic [7:0]  fobs_q[$];

    always @(negedge clk) begin
        if (bus0.imem_rd_en) fobs_q.push_back(bus0.imem_addr);
        if (!rst && bus0.issue_valid && bus0.issue_ready)
            obs_q.push_back({bus0.opcode, bus0.reg1, bus0.reg2, bus0.address});
        if (!rst && bus1.issue_valid && bus1.issue_ready)
            obs1_q.push_back({bus1.opcode, bus1.reg1, bus1.reg2, bus1.address});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete(); obs_q.delete(); obs1_q.delete(); fexp_q.delete(); fobs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; bus0.issue_ready = 1'b1; bus1.issue_ready = 1'b0;
        tick(2);
        rst = 1'b0; start0 = 1'b0;
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy0); end
        tests++; if (halted0 !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted0); end
        tests++; if (pc0 !== 8'h00) begin fails++; $display("FAIL reset_pc0: got %h want 00", pc0); end
        tests++; if (pc1 !== 8'hFF) begin fails++; $display("FAIL reset_pc1: got %h want ff", pc1); end
        tests++; if ({bus0.issue_valid, bus0.imem_rd_en} !== 2'b00) begin
            fails++; $display("FAIL reset_strobes: got valid/rd_en %b want 00", {bus0.issue_valid, bus0.imem_rd_en}); end
        tests++; if (bus0.imem_addr !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h want 00", bus0.imem_addr); end
        tests++; if ({bus0.opcode, bus0.reg1, bus0.reg2, bus0.address} !== 16'h0000) begin
            fails++; $display("FAIL reset_fields: got %h want 0000", {bus0.opcode, bus0.reg1, bus0.reg2, bus0.address}); end
        tick(1);
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_idle_hold: got busy %b want 0", busy0); end
        clear_queues();
    endtask

    task automatic test_basic_backpressure();
        logic [15:0] e, o;
        mem[0] = 16'h1A25; mem[1] = 16'h2B37; mem[2] = 16'hF000;
        exp_q.push_back(16'h1A25); exp_q.push_back(16'h2B37);
        fexp_q.push_back(8'h00); fexp_q.push_back(8'h01); fexp_q.push_back(8'h02);
        bus0.issue_ready = 1'b1;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tests++; if ({bus0.imem_rd_en, bus0.imem_addr} !== {1'b1, 8'h00}) begin
            fails++; $display("FAIL basic_fetch_c1: got rd_en %b addr %h want 1 00", bus0.imem_rd_en, bus0.imem_addr); end
        tick(2);
        tests++; if (bus0.issue_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_c3: got %b want 0", bus0.issue_valid); end
        tick(1);
        tests++; if (bus0.issue_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_c4: got %b want 1", bus0.issue_valid); end
        tests++; if ({bus0.opcode, bus0.reg1, bus0.reg2, bus0.address} !== {4'h1, 2'd2, 2'd2, 8'h25}) begin
            fails++; $display("FAIL basic_fields: got op %h r1 %0d r2 %0d a %h want 1 2 2 25",
                bus0.opcode, bus0.reg1, bus0.reg2, bus0.address); end
        tests++; if (pc0 !== 8'h01) begin fails++; $display("FAIL basic_pc: got %h want 01", pc0); end
        tick(1);
        tests++; if ({bus0.imem_rd_en, bus0.imem_addr, bus0.issue_valid} !== {1'b1, 8'h01, 1'b0}) begin
            fails++; $display("FAIL basic_refetch: got rd_en %b addr %h valid %b want 1 01 0",
                bus0.imem_rd_en, bus0.imem_addr, bus0.issue_valid); end
        bus0.issue_ready = 1'b0;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            tests++; if ({bus0.issue_valid, bus0.opcode, bus0.reg1, bus0.reg2, bus0.address} !== {1'b1, 16'h2B37}) begin
                fails++; $display("FAIL bp_hold[%0d]: got valid %b fields %h want 1 2b37", i,
                    bus0.issue_valid, {bus0.opcode, bus0.reg1, bus0.reg2, bus0.address}); end
            tick(1);
        end
        bus0.issue_ready = 1'b1;
        tick(1);
        tests++; if ({bus0.imem_rd_en, bus0.imem_addr} !== {1'b1, 8'h02}) begin
            fails++; $display("FAIL bp_next_fetch: got rd_en %b addr %h want 1 02", bus0.imem_rd_en, bus0.imem_addr); end
        tick(3);
        tests++; if ({halted0, busy0, pc0} !== {1'b1, 1'b0, 8'h02}) begin
            fails++; $display("FAIL bp_halt: got halted %b busy %b pc %h want 1 0 02", halted0, busy0, pc0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL bp_sb_issue: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL bp_sb_issue: got %h want %h", o, e); end
            end
        end
        while (fexp_q.size() > 0) begin
            e = {8'h00, fexp_q.pop_front()};
            tests++;
            if (fobs_q.size() == 0) begin fails++; $display("FAIL bp_sb_fetch: got none want %h", e[7:0]); end
            else begin
                o = {8'h00, fobs_q.pop_front()};
                if (o !== e) begin fails++; $display("FAIL bp_sb_fetch: got %h want %h", o[7:0], e[7:0]); end
            end
        end
        tests++; if (obs_q.size() + fobs_q.size() != 0) begin
            fails++; $display("FAIL bp_sb_extra: got %0d extra events want 0", obs_q.size() + fobs_q.size()); end
    endtask

    task automatic test_branch_halt();
        int  nf;
        bit  saw_valid;
        logic [7:0] e, o;
        rst = 1'b1; tick(1); rst = 1'b0;
        clear_queues();
        mem[8'h00] = 16'hD001; mem[8'h01] = 16'hE040; mem[8'h40] = 16'hD001;
        mem[8'h02] = 16'hD010; mem[8'h10] = 16'hF000;
        fexp_q = '{8'h00, 8'h01, 8'h40, 8'h01, 8'h02, 8'h10};
        zero = 1'b1; nf = 0; saw_valid = 1'b0;
        start0 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            start0 = 1'b0;
            if (bus0.issue_valid) saw_valid = 1'b1;
            if (bus0.imem_rd_en) begin
                nf++;
                if (nf == 4) zero = 1'b0;
            end
            if (halted0) break;
        end
        tick(1);
        tests++; if (halted0 !== 1'b1) begin fails++; $display("FAIL br_reach_halt: got halted %b want 1", halted0); end
        tests++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL br_no_issue: got valid seen %b want 0", saw_valid); end
        tests++; if ({busy0, pc0} !== {1'b0, 8'h10}) begin
            fails++; $display("FAIL br_halt_state: got busy %b pc %h want 0 10", busy0, pc0); end
        while (fexp_q.size() > 0) begin
            e = fexp_q.pop_front();
            tests++;
            if (fobs_q.size() == 0) begin fails++; $display("FAIL br_sb_fetch: got none want %h", e); end
            else begin
                o = fobs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL br_sb_fetch: got %h want %h", o, e); end
            end
        end
        start0 = 1'b1; tick(1); start0 = 1'b0; tick(3);
        tests++; if ({halted0, busy0, pc0} !== {1'b1, 1'b0, 8'h10}) begin
            fails++; $display("FAIL halt_start_ignored: got halted %b busy %b pc %h want 1 0 10", halted0, busy0, pc0); end
        tests++; if (fobs_q.size() + obs_q.size() != 0) begin
            fails++; $display("FAIL halt_no_activity: got %0d events want 0", fobs_q.size() + obs_q.size()); end
    endtask

    task automatic test_wrap();
        logic [15:0] o;
        mem[8'hFF] = 16'h3C7E; mem[8'h00] = 16'hF000;
        bus1.issue_ready = 1'b1;
        start1 = 1'b1; tick(1); start1 = 1'b0;
        tick(3);
        tests++; if ({bus1.issue_valid, bus1.opcode, bus1.reg1, bus1.reg2, bus1.address} !== {1'b1, 16'h3C7E}) begin
            fails++; $display("FAIL wrap_issue: got valid %b fields %h want 1 3c7e", bus1.issue_valid,
                {bus1.opcode, bus1.reg1, bus1.reg2, bus1.address}); end
        tests++; if (pc1 !== 8'h00) begin fails++; $display("FAIL wrap_pc: got %h want 00", pc1); end
        for (int c = 0; c < 10 && !halted1; c++) tick(1);
        tests++; if ({halted1, busy1, pc1} !== {1'b1, 1'b0, 8'h00}) begin
            fails++; $display("FAIL wrap_halt: got halted %b busy %b pc %h want 1 0 00", halted1, busy1, pc1); end
        start1 = 1'b1; tick(1); start1 = 1'b0; tick(3);
        tests++; if ({halted1, busy1, bus1.imem_rd_en} !== 3'b100) begin
            fails++; $display("FAIL wrap_start_ignored: got halted %b busy %b rd_en %b want 1 0 0", halted1, busy1, bus1.imem_rd_en); end
        tests++;
        if (obs1_q.size() != 1) begin fails++; $display("FAIL wrap_sb: got %0d issues want 1", obs1_q.size()); end
        else begin
            o = obs1_q.pop_front();
            if (o !== 16'h3C7E) begin fails++; $display("FAIL wrap_sb: got %h want 3c7e", o); end
        end
    endtask

    task automatic test_reset_mid_issue();
        rst = 1'b1; tick(1); rst = 1'b0;
        clear_queues();
        mem[0] = 16'h4155;
        bus0.issue_ready = 1'b0;
        start0 = 1'b1; tick(1); start0 = 1'b0;
        for (int c = 0; c < 10 && !bus0.issue_valid; c++) tick(1);
        tests++; if (bus0.issue_valid !== 1'b1) begin fails++; $display("FAIL rmi_reach_issue: got valid %b want 1", bus0.issue_valid); end
        tick(2);
        rst = 1'b1; start0 = 1'b1; bus0.issue_ready = 1'b1;
        tick(1);
        rst = 1'b0; start0 = 1'b0;
        tests++; if ({bus0.issue_valid, busy0, halted0, pc0} !== {3'b000, 8'h00}) begin
            fails++; $display("FAIL rmi_after_rst: got valid %b busy %b halted %b pc %h want 0 0 0 00",
                bus0.issue_valid, busy0, halted0, pc0); end
        tests++; if ({bus0.opcode, bus0.reg1, bus0.reg2, bus0.address} !== 16'h0000) begin
            fails++; $display("FAIL rmi_fields: got %h want 0000", {bus0.opcode, bus0.reg1, bus0.reg2, bus0.address}); end
        tick(1);
        tests++; if ({busy0, obs_q.size() == 0} !== 2'b01) begin
            fails++; $display("FAIL rmi_discard: got busy %b issues %0d want 0 0", busy0, obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        int vcyc[$];
        logic [15:0] e, o;
        clear_queues();
        mem[0] = 16'h5266; mem[1] = 16'h6377; mem[2] = 16'hF000;
        exp_q.push_back(16'h5266); exp_q.push_back(16'h6377);
        bus0.issue_ready = 1'b1;
        start0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            start0 = 1'b0;
            if (bus0.issue_valid) vcyc.push_back(c);
        end
        tests++; if (fobs_q.size() == 0 || fobs_q[0] !== 8'h00) begin
            fails++; $display("FAIL b2b_first_fetch: got %0d fetches first %h want addr 00", fobs_q.size(),
                (fobs_q.size() == 0) ? 8'hxx : fobs_q[0]); end
        tests++; if (vcyc.size() != 2 || vcyc[0] != 4 || vcyc[1] != 8) begin
            fails++; $display("FAIL b2b_timing: got %0d valid cycles first %0d second %0d want cycles 4 8", vcyc.size(),
                (vcyc.size() > 0) ? vcyc[0] : -1, (vcyc.size() > 1) ? vcyc[1] : -1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL b2b_sb: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL b2b_sb: got %h want %h", o, e); end
            end
        end
        tests++; if (halted0 !== 1'b1) begin fails++; $display("FAIL b2b_halt: got %b want 1", halted0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        bus0.issue_ready = 1'b0;
        bus1.issue_ready = 1'b0;
        test_reset();
        test_basic_backpressure();
        test_branch_halt();
        test_wrap();
        test_reset_mid_issue();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
